// File: rtl/pe_feed_pkg.sv
// Shared types and helpers for the systolic-grid skew feeder.
// Optional build macro used by the feeder: PE_FEED_ZERO_PAD_EN.
package pe_feed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } feed_state_t;

    localparam int DEF_N      = 4;
    localparam int DEF_KMAX   = 16;
    localparam int DEF_DWIDTH = 64;

    // Widest lane bus and lane word the slicing helper accepts.
    localparam int LANE_BUS_MAX = 2048;
    localparam int LANE_DW_MAX  = 128;

    function automatic logic [LANE_DW_MAX-1:0] lane_slice(
        input logic [LANE_BUS_MAX-1:0] bus,
        input int                      idx,
        input int                      width
    );
        logic [LANE_BUS_MAX-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[LANE_DW_MAX-1:0];
    endfunction

endpackage

// File: rtl/pe_skew_feeder_skew_line.sv
// Shift-enabled delay line of {en, data}; the last stage is the lane output register.
// With PE_FEED_ZERO_PAD_EN defined, bubbles load zero data instead of holding.
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_shift,
    input  logic              i_en,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_en,
    output logic [DWIDTH-1:0] o_data
);

    logic              r_en      [DEPTH];
    logic [DWIDTH-1:0] r_data    [DEPTH];
    logic              w_srcEn   [DEPTH];
    logic [DWIDTH-1:0] w_srcData [DEPTH];

    always_comb begin
        w_srcEn[0]   = i_en;
        w_srcData[0] = i_data;
        for (int s = 1; s < DEPTH; s++) begin
            w_srcEn[s]   = r_en[s-1];
            w_srcData[s] = r_data[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_en[s]   <= 1'b0;
                r_data[s] <= '0;
            end
        end else if (i_shift) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_en[s] <= w_srcEn[s];
`ifdef PE_FEED_ZERO_PAD_EN
                r_data[s] <= w_srcEn[s] ? w_srcData[s] : '0;
`else
                if (w_srcEn[s]) begin
                    r_data[s] <= w_srcData[s];
                end
`endif
            end
        end
    end

    assign o_en   = r_en[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// Skews A/B operand beats onto the west/north edges of the PE grid, paced by advance.
// Bubble data handling selected by PE_FEED_ZERO_PAD_EN (undefined: data holds).
module pe_skew_feeder
    import pe_feed_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int N      = DEF_N,
    parameter int KMAX   = DEF_KMAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [N*DWIDTH-1:0] in_a,
    input  logic [N*DWIDTH-1:0] in_b,
    output logic [N*DWIDTH-1:0] a_edge,
    output logic [N*DWIDTH-1:0] b_edge,
    output logic [N-1:0]        lane_en,
    output logic                busy,
    output logic                done,
    output logic                truncated
);

    localparam int CW  = $clog2(KMAX + 1);
    localparam int DCW = (N > 1) ? $clog2(N) : 1;

    feed_state_t    r_state;
    logic [CW-1:0]  r_beats;
    logic [DCW-1:0] r_drainCnt;
    logic           r_busy;
    logic           r_done;
    logic           r_trunc;

    logic           w_take;
    logic [CW-1:0]  w_beatsInc;
    logic           w_atKmax;
    logic           w_endLoad;

    assign in_ready   = advance && (r_state == IDLE || r_state == LOAD);
    assign w_take     = in_ready && in_valid;
    assign w_beatsInc = r_beats + 1'b1;
    assign w_atKmax   = (w_beatsInc == CW'(KMAX));
    assign w_endLoad  = w_take && (in_last || w_atKmax);

    // A single-beat job may end on the very beat that starts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beats    <= '0;
            r_drainCnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOAD: begin
                    if (w_take) begin
                        r_busy  <= 1'b1;
                        r_beats <= w_beatsInc;
                        if (r_state == IDLE) begin
                            r_trunc <= 1'b0;
                        end
                        if (w_endLoad) begin
                            if (!in_last) begin
                                r_trunc <= 1'b1;
                            end
                            r_drainCnt <= '0;
                            if (N == 1) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (r_drainCnt == DCW'(N - 2)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_drainCnt <= r_drainCnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_beats <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign truncated = r_trunc;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DWIDTH-1:0] w_laneA;
        logic [DWIDTH-1:0] w_laneB;
        logic              w_aEn;
        logic              w_bEn;

        assign w_laneA = DWIDTH'(lane_slice(LANE_BUS_MAX'(in_a), i, DWIDTH));
        assign w_laneB = DWIDTH'(lane_slice(LANE_BUS_MAX'(in_b), i, DWIDTH));

        skew_line #(.DEPTH(i + 1), .DWIDTH(DWIDTH)) u_lineA (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_shift (advance),
            .i_en    (w_take),
            .i_data  (w_laneA),
            .o_en    (w_aEn),
            .o_data  (a_edge[i*DWIDTH +: DWIDTH])
        );

        skew_line #(.DEPTH(i + 1), .DWIDTH(DWIDTH)) u_lineB (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_shift (advance),
            .i_en    (w_take),
            .i_data  (w_laneB),
            .o_en    (w_bEn),
            .o_data  (b_edge[i*DWIDTH +: DWIDTH])
        );

        // Both lines carry the same tag; combining them keeps each observable.
        assign lane_en[i] = w_aEn & w_bEn;
    end

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder (N=4 instance plus an N=1 instance).
// Bubble data expectations follow PE_FEED_ZERO_PAD_EN when it is defined.
module tb_pe_skew_feeder;

    localparam int DW = 64;
    localparam int NL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             advance;
    logic             inValid;
    logic             inReady;
    logic             inLast;
    logic [NL*DW-1:0] inA;
    logic [NL*DW-1:0] inB;
    logic [NL*DW-1:0] aEdge;
    logic [NL*DW-1:0] bEdge;
    logic [NL-1:0]    laneEn;
    logic             busy;
    logic             done;
    logic             truncated;

    logic          adv1;
    logic          valid1;
    logic          ready1;
    logic          last1;
    logic [DW-1:0] a1;
    logic [DW-1:0] b1;
    logic [DW-1:0] aEdge1;
    logic [DW-1:0] bEdge1;
    logic [0:0]    laneEn1;
    logic          busy1;
    logic          done1;
    logic          trunc1;

    int passCount  = 0;
    int checkCount = 0;
    int hist[$];

    always #5 clk = ~clk;

    pe_skew_feeder #(.DWIDTH(DW), .N(NL), .KMAX(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_last   (inLast),
        .in_a      (inA),
        .in_b      (inB),
        .a_edge    (aEdge),
        .b_edge    (bEdge),
        .lane_en   (laneEn),
        .busy      (busy),
        .done      (done),
        .truncated (truncated)
    );

    pe_skew_feeder #(.DWIDTH(DW), .N(1), .KMAX(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (adv1),
        .in_valid  (valid1),
        .in_ready  (ready1),
        .in_last   (last1),
        .in_a      (a1),
        .in_b      (b1),
        .a_edge    (aEdge1),
        .b_edge    (bEdge1),
        .lane_en   (laneEn1),
        .busy      (busy1),
        .done      (done1),
        .truncated (trunc1)
    );

    function automatic logic [DW-1:0] aVal(input int i, input int k);
        return DW'(16 * i + k);
    endfunction

    function automatic logic [DW-1:0] bVal(input int j, input int k);
        return DW'(256 + 16 * k + j);
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // hist holds one entry per advance since reset: beat index k, or -1 for a bubble.
    function automatic void expLane(input int i, output bit en,
                                    output logic [DW-1:0] da, output logic [DW-1:0] db);
        int p;
        p  = hist.size() - 1 - i;
        en = 1'b0;
        da = '0;
        db = '0;
        if (p >= 0 && hist[p] >= 0) begin
            en = 1'b1;
            da = aVal(i, hist[p]);
            db = bVal(i, hist[p]);
        end
`ifndef PE_FEED_ZERO_PAD_EN
        else begin
            for (int q = p - 1; q >= 0; q--) begin
                if (hist[q] >= 0) begin
                    da = aVal(i, hist[q]);
                    db = bVal(i, hist[q]);
                    break;
                end
            end
        end
`endif
    endfunction

    task automatic checkLanes();
        bit            en;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        for (int i = 0; i < NL; i++) begin
            expLane(i, en, da, db);
            checkOutput($sformatf("laneEn%0d", i), DW'(laneEn[i]), DW'(en));
            checkOutput($sformatf("aEdge%0d", i), aEdge[i*DW +: DW], da);
            checkOutput($sformatf("bEdge%0d", i), bEdge[i*DW +: DW], db);
        end
    endtask

    task automatic drive(input bit adv, input bit valid, input bit last, input int k);
        advance = adv;
        inValid = valid;
        inLast  = last;
        for (int i = 0; i < NL; i++) begin
            inA[i*DW +: DW] = aVal(i, k);
            inB[i*DW +: DW] = bVal(i, k);
        end
    endtask

    // gap non-advancing cycles precede the advancing one; lanes are checked after every edge.
    task automatic applyStimulus(input bit adv, input bit valid, input bit last, input int k,
                                 input bit expReady, input int gap);
        for (int g = 0; g < gap; g++) begin
            drive(1'b0, valid, last, k);
            #1;
            checkOutput("inReadyHold", DW'(inReady), '0);
            @(posedge clk);
            #1;
            checkLanes();
        end
        drive(adv, valid, last, k);
        #1;
        checkOutput("inReady", DW'(inReady), DW'(adv && expReady));
        @(posedge clk);
        if (adv) begin
            hist.push_back((valid && expReady) ? k : -1);
        end
        #1;
        checkLanes();
    endtask

    task automatic drainJob(input int gap);
        for (int d = 0; d < NL - 1; d++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, gap);
            checkOutput("drainDone", DW'(done), DW'(d == NL - 2));
            checkOutput("drainBusy", DW'(busy), 64'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        checkOutput("doneClr", DW'(done), '0);
        checkOutput("busyClr", DW'(busy), '0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        inA = '0;
        inB = '0;
        adv1 = 1'b0; valid1 = 1'b0; last1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        checkOutput("rstBusy", DW'(busy), '0);
        checkOutput("rstDone", DW'(done), '0);
        checkOutput("rstTrunc", DW'(truncated), '0);
        checkOutput("rstReady", DW'(inReady), '0);
        checkOutput("rstBusy1", DW'(busy1), '0);
        checkOutput("rstDone1", DW'(done1), '0);
        checkLanes();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] job 1: K=4, advance every cycle");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, k == 3, k, 1'b1, 0);
            if (k == 0) checkOutput("busyStart", DW'(busy), 64'd1);
            if (k == 2) checkOutput("lane2A0", aEdge[2*DW +: DW], 64'h20);
        end
        checkOutput("lane2A1", aEdge[2*DW +: DW], 64'h21);
        drainJob(0);
        checkOutput("trunc1", DW'(truncated), '0);

        $display("[TB] job 2: K=4, advance every 5th cycle");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, k == 3, k, 1'b1, 4);
        end
        for (int d = 0; d < NL - 1; d++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 4);
            checkOutput("slowDone", DW'(done), DW'(d == NL - 2));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        checkOutput("slowDoneClr", DW'(done), '0);

        $display("[TB] job 3: bubble mid-job");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
        checkOutput("bubEn0", DW'(laneEn[0]), '0);
`ifdef PE_FEED_ZERO_PAD_EN
        checkOutput("bubA0", aEdge[0 +: DW], 64'h0);
`else
        checkOutput("bubA0", aEdge[0 +: DW], 64'h1);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, 0);
        checkOutput("bubEn1", DW'(laneEn[1]), '0);
        checkOutput("bubEn0b", DW'(laneEn[0]), 64'd1);
        checkOutput("bubA0b", aEdge[0 +: DW], 64'h2);
`ifdef PE_FEED_ZERO_PAD_EN
        checkOutput("bubA1", aEdge[DW +: DW], 64'h0);
`else
        checkOutput("bubA1", aEdge[DW +: DW], 64'h11);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 1'b1, 0);
        drainJob(0);

        $display("[TB] job 4: KMAX beats without in_last");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, k, 1'b1, 0);
            if (k == 14) checkOutput("truncEarly", DW'(truncated), '0);
        end
        checkOutput("truncSet", DW'(truncated), 64'd1);
        for (int d = 0; d < NL - 1; d++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
            checkOutput("truncDone", DW'(done), DW'(d == NL - 2));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        checkOutput("truncSticky", DW'(truncated), 64'd1);

        $display("[TB] job 5: reset during DRAIN");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        checkOutput("truncClr", DW'(truncated), '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        advance = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        hist.delete();
        checkOutput("midRstBusy", DW'(busy), '0);
        checkOutput("midRstDone", DW'(done), '0);
        checkOutput("midRstReady", DW'(inReady), '0);
        checkLanes();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b1, 0);
        drainJob(0);

        $display("[TB] job 6: N=1, K=1");
        adv1 = 1'b1; valid1 = 1'b1; last1 = 1'b1; a1 = 64'hA5; b1 = 64'h5A;
        #1;
        checkOutput("n1Ready", DW'(ready1), 64'd1);
        @(posedge clk);
        #1;
        adv1 = 1'b0; valid1 = 1'b0; last1 = 1'b0;
        checkOutput("n1A", aEdge1, 64'hA5);
        checkOutput("n1B", bEdge1, 64'h5A);
        checkOutput("n1En", DW'(laneEn1), 64'd1);
        checkOutput("n1Done", DW'(done1), 64'd1);
        checkOutput("n1Busy", DW'(busy1), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("n1DoneClr", DW'(done1), '0);
        checkOutput("n1BusyClr", DW'(busy1), '0);
        checkOutput("n1Trunc", DW'(trunc1), '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
